// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - operand, control and result bundle for alu_muldiv
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic             start;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output a, b, sel, start,
        input  result, zero, busy, done, hi, lo
    );

    modport slave (
        input  a, b, sel, start,
        output result, zero, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - single-cycle ALU with iterative mul/div writing HI/LO
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    alu_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;   // partial product high half / division remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier bits / dividend shifting into quotient
    logic [WIDTH-1:0] mb;       // divisor or multiplicand magnitude
    logic [WIDTH-1:0] a_q;      // raw dividend kept for the divide-by-zero result
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             op_div;
    logic             b_zero;
    logic             neg_q;    // negate product / quotient at the end
    logic             neg_r;    // negate remainder (dividend was negative)
    logic             done_q;

    // Launch decode: 1010..1101 are mul/div; sel[0]=0 is the signed flavour.
    logic             launch;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb_in;

    assign launch    = bus.sel[3] & (bus.sel[2] ^ bus.sel[1]);
    assign op_signed = ~bus.sel[0];
    assign a_neg     = op_signed & bus.a[WIDTH-1];
    assign b_neg     = op_signed & bus.b[WIDTH-1];
    assign ma        = a_neg ? -bus.a : bus.a;
    assign mb_in     = b_neg ? -bus.b : bus.b;

    // One shift-add multiply step and one restoring-divide step.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mb} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mb};
    assign div_diff  = div_shift[WIDTH-1:0] - mb;

    // Sign correction applied in FIX.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign q_fix    = neg_q ? -acc_lo : acc_lo;
    assign r_fix    = neg_r ? -acc_hi : acc_hi;

    // Mul/div sequencer: IDLE -> ITER (WIDTH steps) -> FIX -> IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mb     <= '0;
            a_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            op_div <= 1'b0;
            b_zero <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start && launch) begin
                        acc_hi <= '0;
                        acc_lo <= ma;
                        mb     <= mb_in;
                        a_q    <= bus.a;
                        op_div <= bus.sel[2];
                        b_zero <= (bus.b == '0);
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg & bus.sel[2];
                        cnt    <= '0;
                        state  <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (op_div) begin
                        acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!op_div) begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else if (b_zero) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= r_fix;
                        lo_q <= q_fix;
                    end
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Single-cycle result mux; mul/div and reserved selects read as zero.
    logic [WIDTH-1:0] res;
    always_comb begin
        res = '0;
        case (bus.sel)
            4'b0000: res = bus.a & bus.b;
            4'b0001: res = bus.a | bus.b;
            4'b0010: res = bus.a + bus.b;
            4'b0011: res[0] = bus.a < bus.b;
            4'b0100: res = bus.a & ~bus.b;
            4'b0101: res = bus.a | ~bus.b;
            4'b0110: res = bus.a - bus.b;
            4'b0111: res[0] = $signed(bus.a) < $signed(bus.b);
            4'b1000: res = hi_q;
            4'b1001: res = lo_q;
            default: res = '0;
        endcase
    end

    assign bus.result = res;
    assign bus.zero   = (res == '0);
    assign bus.busy   = (state != S_IDLE);
    assign bus.done   = done_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard bench for alu_muldiv
module tb_alu_muldiv;
    localparam int W = 32;
    localparam logic [3:0] MFHI = 4'b1000, MFLO = 4'b1001, MULT = 4'b1010,
                           MULTU = 4'b1011, DIV = 4'b1100, DIVU = 4'b1101;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;

    logic [63:0] sb[$];
    int          done_cyc[$];
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    alu_muldiv_if #(.WIDTH(W)) ifc ();
    alu_muldiv #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(ifc.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] s, input logic [31:0] x,
                                              input logic [31:0] y, input logic [31:0] h,
                                              input logic [31:0] l);
        case (s)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0011: return {31'b0, x < y};
            4'b0100: return x & ~y;
            4'b0101: return x | ~y;
            4'b0110: return x - y;
            4'b0111: return {31'b0, $signed(x) < $signed(y)};
            4'b1000: return h;
            4'b1001: return l;
            default: return 32'b0;
        endcase
    endfunction

    // Returns {hi, lo}.
    function automatic logic [63:0] md_model(input logic [3:0] s, input logic [31:0] x,
                                             input logic [31:0] y);
        longint sx, sy;
        logic [63:0] p;
        int q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (s)
            MULT:  begin p = sx * sy; return p; end
            MULTU: begin p = {32'b0, x} * {32'b0, y}; return p; end
            DIV: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Completion monitor: pop the oldest expectation on every done pulse.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset && ifc.done) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("hi", {32'b0, ifc.hi}, {32'b0, e[63:32]});
                check("lo", {32'b0, ifc.lo}, {32'b0, e[31:0]});
                last_hi = e[63:32];
                last_lo = e[31:0];
                done_cyc.push_back(cyc);
            end
        end
    end

    // Drive at a negedge; returns at the done-cycle negedge.
    task automatic run_op(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
        int n;
        ifc.sel = s;
        ifc.a = x;
        ifc.b = y;
        ifc.start = 1'b1;
        sb.push_back(md_model(s, x, y));
        n = 0;
        @(negedge clk);
        ifc.start = 1'b0;
        while (ifc.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("busy_len", 64'(n), 64'd33);
        check("done_pulse", {63'b0, ifc.done}, 64'd1);
    endtask

    logic [31:0] ra, rb;
    logic [3:0]  rs;
    int          n;

    initial begin
        ifc.a = '0;
        ifc.b = '0;
        ifc.sel = '0;
        ifc.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'b0, ifc.busy}, 64'd0);
        check("rst_done", {63'b0, ifc.done}, 64'd0);
        check("rst_hi", {32'b0, ifc.hi}, 64'd0);
        check("rst_lo", {32'b0, ifc.lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single-cycle ops on fixed operands, every select code.
        for (int s = 0; s < 16; s++) begin
            ifc.sel = 4'(s);
            ifc.a = 32'h0000_00F0;
            ifc.b = 32'h0000_0F0F;
            #1;
            check($sformatf("alu_%0d", s), {32'b0, ifc.result},
                  {32'b0, alu_model(4'(s), 32'h0000_00F0, 32'h0000_0F0F, 32'h0, 32'h0)});
        end
        ifc.sel = 4'b0110;
        ifc.b = 32'h0000_00F0;
        #1;
        check("zero_eq", {63'b0, ifc.zero}, 64'd1);
        ifc.a = 32'h8000_0000;
        ifc.b = 32'h1;
        ifc.sel = 4'b0111;
        #1;
        check("slt_neg", {32'b0, ifc.result}, 64'd1);
        ifc.sel = 4'b0011;
        #1;
        check("sltu_big", {32'b0, ifc.result}, 64'd0);
        @(negedge clk);

        // Directed mul/div including the corner cases.
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(MULT, 32'hFFFF_FFFD, 32'd7);
        run_op(DIV, 32'hFFFF_FFF9, 32'd2);
        run_op(DIVU, 32'd100, 32'd0);
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(MULT, 32'h1234_5678, 32'h9ABC_DEF0);

        // Ignored restarts and operand churn during busy; mfhi/mflo show old values.
        ifc.sel = MULTU;
        ifc.a = 32'hDEAD_BEEF;
        ifc.b = 32'h0BAD_F00D;
        ifc.start = 1'b1;
        sb.push_back(md_model(MULTU, 32'hDEAD_BEEF, 32'h0BAD_F00D));
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            ifc.a = $urandom;
            ifc.b = $urandom;
            ifc.sel = (i % 2) ? DIV : MULT;
            @(negedge clk);
        end
        ifc.start = 1'b0;
        ifc.sel = MFHI;
        #1;
        check("mfhi_busy", {32'b0, ifc.result}, {32'b0, last_hi});
        ifc.sel = MFLO;
        #1;
        check("mflo_busy", {32'b0, ifc.result}, {32'b0, last_lo});
        n = 0;
        while (ifc.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("churn_idle", 64'(n < 200), 64'd1);
        @(negedge clk);
        check("churn_drain", 64'(sb.size()), 64'd0);

        // Reset in the middle of the iterations.
        ifc.sel = DIV;
        ifc.a = 32'h7654_3210;
        ifc.b = 32'h0000_0123;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", {63'b0, ifc.busy}, 64'd0);
        check("mid_rst_done", {63'b0, ifc.done}, 64'd0);
        check("mid_rst_hi", {32'b0, ifc.hi}, 64'd0);
        check("mid_rst_lo", {32'b0, ifc.lo}, 64'd0);
        last_hi = '0;
        last_lo = '0;
        run_op(DIVU, 32'd1000, 32'd7);

        // Back-to-back: second start in the first op's done cycle.
        done_cyc.delete();
        run_op(MULT, 32'hFFFF_0001, 32'h0001_FFFF);
        run_op(DIVU, 32'hFFFF_FFF0, 32'd3);
        if (done_cyc.size() == 2)
            check("b2b_gap", 64'(done_cyc[1] - done_cyc[0] - 1), 64'd33);
        else
            check("b2b_count", 64'(done_cyc.size()), 64'd2);

        // Random regression against the reference model.
        for (int i = 0; i < 300; i++) begin
            rs = 4'(10 + $urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'(32'($urandom_range(0, 20)));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            run_op(rs, ra, rb);
        end

        @(negedge clk);
        check("final_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
